// File: rtl/riscv_pkg.sv
// Shared opcode, ALU-operation and id_ctrl bit definitions for the RV32I decode stage.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALUOP_ADD  = 3'd0;
    localparam logic [2:0] ALUOP_SLL  = 3'd1;
    localparam logic [2:0] ALUOP_SLT  = 3'd2;
    localparam logic [2:0] ALUOP_SLTU = 3'd3;
    localparam logic [2:0] ALUOP_XOR  = 3'd4;
    localparam logic [2:0] ALUOP_SR   = 3'd5;
    localparam logic [2:0] ALUOP_OR   = 3'd6;
    localparam logic [2:0] ALUOP_AND  = 3'd7;

    localparam int CTRL_W        = 6;
    localparam int CTRL_WEN      = 5;
    localparam int CTRL_MEM_RD   = 4;
    localparam int CTRL_MEM_WR   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_JUMP     = 1;
    localparam int CTRL_JUMP_REG = 0;

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch/regfile/ID-EX signal bundle for riscv_decode_stage.
// ILLEGAL_TRAP_EN adds the id_illegal field.
interface riscv_decode_stage_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            ex_ready;
    logic [4:0]      rf_rs1_addr;
    logic [4:0]      rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_aluop;
    logic            id_asrc;
    logic            id_bsrc;
    logic            id_sra;
    logic            id_shdir;
    logic            id_sub;
    logic            id_jalr;
    logic [4:0]      id_rd;
    logic [5:0]      id_ctrl;
    logic [2:0]      id_funct3;
`ifdef ILLEGAL_TRAP_EN
    logic            id_illegal;
`endif

    modport slave (
`ifdef ILLEGAL_TRAP_EN
        output id_illegal,
`endif
        input  if_valid, if_instr, if_pc, flush, ex_ready, rf_rs1_data, rf_rs2_data,
        output if_ready, rf_rs1_addr, rf_rs2_addr, id_valid, id_pc, id_rs1_data,
               id_rs2_data, id_imm, id_aluop, id_asrc, id_bsrc, id_sra, id_shdir,
               id_sub, id_jalr, id_rd, id_ctrl, id_funct3
    );

    modport master (
`ifdef ILLEGAL_TRAP_EN
        input  id_illegal,
`endif
        output if_valid, if_instr, if_pc, flush, ex_ready, rf_rs1_data, rf_rs2_data,
        input  if_ready, rf_rs1_addr, rf_rs2_addr, id_valid, id_pc, id_rs1_data,
               id_rs2_data, id_imm, id_aluop, id_asrc, id_bsrc, id_sra, id_shdir,
               id_sub, id_jalr, id_rd, id_ctrl, id_funct3
    );
endinterface

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate generator; formats without an immediate yield 0.
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_JALR, OPC_LOAD:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: control decode, register-file read and the ID/EX register.
// ILLEGAL_TRAP_EN adds id_illegal for unknown opcodes / non-32-bit encodings.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_decode_stage_if.slave  bus
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic              f7b5;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [2:0]        aluop;
    logic              asrc, bsrc, sra, shdir, sub, jalr, wen_req;
    logic [CTRL_W-1:0] ctrl;
    logic              load;

    assign opc  = bus.if_instr[6:0];
    assign f3   = bus.if_instr[14:12];
    assign f7b5 = bus.if_instr[30];
    assign rd   = bus.if_instr[11:7];

    // LUI reads x0 so a shared A-operand path sees zero.
    assign bus.rf_rs1_addr = (opc == OPC_LUI) ? 5'd0 : bus.if_instr[19:15];
    assign bus.rf_rs2_addr = bus.if_instr[24:20];

    riscv_imm_gen u_imm_gen (
        .instr (bus.if_instr),
        .imm   (imm)
    );

    always_comb begin
        aluop   = ALUOP_ADD;
        asrc    = 1'b0;
        bsrc    = 1'b0;
        sra     = 1'b0;
        shdir   = 1'b0;
        sub     = 1'b0;
        jalr    = 1'b0;
        wen_req = 1'b0;
        ctrl    = '0;
        case (opc)
            OPC_OP: begin
                aluop   = f3;
                sub     = f7b5 && (f3 == 3'd0);
                sra     = f7b5 && (f3 == ALUOP_SR);
                shdir   = (f3 == ALUOP_SLL);
                wen_req = 1'b1;
            end
            OPC_OP_IMM: begin
                aluop   = f3;
                bsrc    = 1'b1;
                sra     = f7b5 && (f3 == ALUOP_SR);
                shdir   = (f3 == ALUOP_SLL);
                wen_req = 1'b1;
            end
            OPC_LUI: begin
                bsrc    = 1'b1;
                wen_req = 1'b1;
            end
            OPC_AUIPC: begin
                asrc    = 1'b1;
                bsrc    = 1'b1;
                wen_req = 1'b1;
            end
            OPC_JAL: begin
                asrc            = 1'b1;
                jalr            = 1'b1;
                ctrl[CTRL_JUMP] = 1'b1;
                wen_req         = 1'b1;
            end
            OPC_JALR: begin
                asrc                = 1'b1;
                jalr                = 1'b1;
                ctrl[CTRL_JUMP_REG] = 1'b1;
                wen_req             = 1'b1;
            end
            OPC_BRANCH: begin
                sub               = 1'b1;
                ctrl[CTRL_BRANCH] = 1'b1;
            end
            OPC_LOAD: begin
                bsrc              = 1'b1;
                ctrl[CTRL_MEM_RD] = 1'b1;
                wen_req           = 1'b1;
            end
            OPC_STORE: begin
                bsrc              = 1'b1;
                ctrl[CTRL_MEM_WR] = 1'b1;
            end
            default: ;
        endcase
        ctrl[CTRL_WEN] = wen_req && (rd != 5'd0);
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal;

    // Full 7-bit compare also rejects encodings whose low bits are not 2'b11.
    always_comb begin
        illegal = 1'b1;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_FENCE, OPC_SYSTEM:
                illegal = 1'b0;
            default:
                illegal = 1'b1;
        endcase
    end
`endif

    assign bus.if_ready = !bus.id_valid || bus.ex_ready;
    assign load         = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.id_valid    <= 1'b0;
            bus.id_pc       <= RESET_PC;
            bus.id_rs1_data <= '0;
            bus.id_rs2_data <= '0;
            bus.id_imm      <= '0;
            bus.id_aluop    <= '0;
            bus.id_asrc     <= 1'b0;
            bus.id_bsrc     <= 1'b0;
            bus.id_sra      <= 1'b0;
            bus.id_shdir    <= 1'b0;
            bus.id_sub      <= 1'b0;
            bus.id_jalr     <= 1'b0;
            bus.id_rd       <= '0;
            bus.id_ctrl     <= '0;
            bus.id_funct3   <= '0;
`ifdef ILLEGAL_TRAP_EN
            bus.id_illegal  <= 1'b0;
`endif
        end else if (bus.flush) begin
            bus.id_valid <= 1'b0;
        end else if (load) begin
            bus.id_valid    <= 1'b1;
            bus.id_pc       <= bus.if_pc;
            bus.id_rs1_data <= bus.rf_rs1_data;
            bus.id_rs2_data <= bus.rf_rs2_data;
            bus.id_imm      <= imm;
            bus.id_aluop    <= aluop;
            bus.id_asrc     <= asrc;
            bus.id_bsrc     <= bsrc;
            bus.id_sra      <= sra;
            bus.id_shdir    <= shdir;
            bus.id_sub      <= sub;
            bus.id_jalr     <= jalr;
            bus.id_rd       <= rd;
            bus.id_ctrl     <= ctrl;
            bus.id_funct3   <= f3;
`ifdef ILLEGAL_TRAP_EN
            bus.id_illegal  <= illegal;
`endif
        end else if (bus.ex_ready) begin
            bus.id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Randomized + directed bench for riscv_decode_stage against a behavioural decode model.
// Checks id_illegal when built with ILLEGAL_TRAP_EN.
module tb_riscv_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_decode_stage_if bus ();

    riscv_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] regs [32];
    assign bus.rf_rs1_data = regs[bus.rf_rs1_addr];
    assign bus.rf_rs2_data = regs[bus.rf_rs2_addr];

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1, rs2, imm;
        logic [2:0]  aluop;
        logic        asrc, bsrc, sra, shdir, sub, jalr;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        logic [2:0]  f3;
        logic        illegal;
    } exp_t;

    exp_t m;
    int   total = 0;
    int   bad = 0;
    logic exp_ready, obs_ready;

    // Reference decode written from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic wr;
        logic [6:0] op;
        logic [2:0] f;
        op = i[6:0];
        f  = i[14:12];
        wr = 1'b0;
        e = '{valid: 1'b1, pc: pc, rs1: regs[i[19:15]], rs2: regs[i[24:20]], imm: 32'd0,
              aluop: 3'd0, asrc: 1'b0, bsrc: 1'b0, sra: 1'b0, shdir: 1'b0, sub: 1'b0,
              jalr: 1'b0, rd: i[11:7], ctrl: 6'd0, f3: f, illegal: 1'b0};
        case (op)
            7'h33: begin e.aluop = f; e.sub = i[30] && f == 0; e.sra = i[30] && f == 5;
                         e.shdir = (f == 1); wr = 1; end
            7'h13: begin e.aluop = f; e.bsrc = 1; e.sra = i[30] && f == 5; e.shdir = (f == 1);
                         e.imm = int'($signed(i[31:20])); wr = 1; end
            7'h37: begin e.rs1 = regs[0]; e.bsrc = 1; e.imm = {i[31:12], 12'h000}; wr = 1; end
            7'h17: begin e.asrc = 1; e.bsrc = 1; e.imm = {i[31:12], 12'h000}; wr = 1; end
            7'h6F: begin e.asrc = 1; e.jalr = 1; e.ctrl = 6'b000010; wr = 1;
                         e.imm = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin e.asrc = 1; e.jalr = 1; e.ctrl = 6'b000001; wr = 1;
                         e.imm = int'($signed(i[31:20])); end
            7'h63: begin e.sub = 1; e.ctrl = 6'b000100;
                         e.imm = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h03: begin e.bsrc = 1; e.ctrl = 6'b010000; wr = 1; e.imm = int'($signed(i[31:20])); end
            7'h23: begin e.bsrc = 1; e.ctrl = 6'b001000; e.imm = int'($signed({i[31:25], i[11:7]})); end
            7'h0F, 7'h73: ;
            default: e.illegal = 1'b1;
        endcase
        if (wr && i[11:7] != 5'd0) e.ctrl[5] = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73, 7'h00};
        r = $urandom();
        if ($urandom_range(0, 11) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 11)]};
    endfunction

    // One clock of stimulus; advances the model, leaves time at posedge+1.
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic exr, input logic fl);
        @(negedge clk);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.ex_ready = exr;
        bus.flush    = fl;
        #1;
        obs_ready = bus.if_ready;
        exp_ready = !m.valid || exr;
        @(posedge clk);
        if (fl) m.valid = 1'b0;
        else if (v && exp_ready) m = ref_decode(instr, pc);
        else if (exr) m.valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.id_valid); end
        total++; if (bus.id_pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", bus.id_pc, RST_PC); end
        total++; if ({bus.id_imm, bus.id_rs1_data, bus.id_rs2_data, bus.id_ctrl, bus.id_rd, bus.id_aluop} !== '0) begin
            bad++; $display("FAIL reset_fields got imm=%h ctrl=%b rd=%0d want all zero", bus.id_imm, bus.id_ctrl, bus.id_rd); end
        total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.if_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        m.valid = 1'b0;
    endtask

    task automatic test_directed();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        drive(1, 32'h002081B3, 32'h0000_0040, 1, 0);
        total++; if (bus.id_valid !== 1'b1 || bus.id_rd !== 5'd3 || bus.id_ctrl !== 6'b100000) begin
            bad++; $display("FAIL add_ctl got valid=%0b rd=%0d ctrl=%b want 1/3/100000", bus.id_valid, bus.id_rd, bus.id_ctrl); end
        total++; if ({bus.id_aluop, bus.id_sub, bus.id_asrc, bus.id_bsrc} !== 6'd0) begin
            bad++; $display("FAIL add_alu got aluop=%0d sub=%0b asrc=%0b bsrc=%0b want 0", bus.id_aluop, bus.id_sub, bus.id_asrc, bus.id_bsrc); end
        total++; if (bus.id_rs1_data !== 32'd5 || bus.id_rs2_data !== 32'd7) begin
            bad++; $display("FAIL add_rs got=%0d/%0d want=5/7", bus.id_rs1_data, bus.id_rs2_data); end
        drive(1, 32'h40335293, 32'h0000_0044, 1, 0);
        total++; if (bus.id_aluop !== 3'd5 || bus.id_sra !== 1'b1 || bus.id_shdir !== 1'b0 || bus.id_bsrc !== 1'b1) begin
            bad++; $display("FAIL srai_alu got aluop=%0d sra=%0b shdir=%0b bsrc=%0b want 5/1/0/1", bus.id_aluop, bus.id_sra, bus.id_shdir, bus.id_bsrc); end
        total++; if (bus.id_imm !== 32'h0000_0403 || bus.id_rd !== 5'd5) begin
            bad++; $display("FAIL srai_imm got imm=%h rd=%0d want 00000403/5", bus.id_imm, bus.id_rd); end
        drive(1, 32'hFE000EE3, 32'h0000_0048, 1, 0);
        total++; if (bus.id_imm !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL beq_imm got=%h want=fffffffc", bus.id_imm); end
        total++; if (bus.id_sub !== 1'b1 || bus.id_ctrl !== 6'b000100) begin
            bad++; $display("FAIL beq_ctl got sub=%0b ctrl=%b want 1/000100", bus.id_sub, bus.id_ctrl); end
    endtask

    task automatic test_stall();
        drive(1, 32'h002081B3, 32'h0000_0200, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h40208233, 32'h0000_0204, 0, 0);
            total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%0b want=0", k, obs_ready); end
            total++; if (bus.id_valid !== 1'b1 || bus.id_rd !== 5'd3 || bus.id_pc !== 32'h200 || bus.id_sub !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d got valid=%0b rd=%0d pc=%h sub=%0b want 1/3/200/0", k, bus.id_valid, bus.id_rd, bus.id_pc, bus.id_sub); end
        end
        drive(1, 32'h40208233, 32'h0000_0204, 1, 0);
        total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL unstall_ready got=%0b want=1", obs_ready); end
        total++; if (bus.id_rd !== 5'd4 || bus.id_pc !== 32'h204 || bus.id_sub !== 1'b1) begin
            bad++; $display("FAIL unstall_load got rd=%0d pc=%h sub=%0b want 4/204/1", bus.id_rd, bus.id_pc, bus.id_sub); end
    endtask

    task automatic test_flush_reset();
        drive(1, 32'h002081B3, 32'h0000_0300, 1, 0);
        drive(1, 32'h40335293, 32'h0000_0304, 1, 1);
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", bus.id_valid); end
        drive(1, 32'h40335293, 32'h0000_0308, 0, 0);
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h308) begin
            bad++; $display("FAIL post_flush_load got valid=%0b pc=%h want 1/308", bus.id_valid, bus.id_pc); end
        drive(1, 32'hFE000EE3, 32'h0000_030C, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.id_valid !== 1'b0 || bus.id_pc !== RST_PC) begin
            bad++; $display("FAIL midstall_reset got valid=%0b pc=%h want 0/%h", bus.id_valid, bus.id_pc, RST_PC); end
        total++; if ({bus.id_imm, bus.id_rs1_data, bus.id_aluop, bus.id_sra, bus.id_bsrc, bus.id_rd, bus.id_ctrl} !== '0) begin
            bad++; $display("FAIL midstall_fields got imm=%h rs1=%h rd=%0d ctrl=%b want 0", bus.id_imm, bus.id_rs1_data, bus.id_rd, bus.id_ctrl); end
        @(negedge clk);
        rst_n = 1'b1;
        m.valid = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1, 32'hFFFF_FFFF, 32'h0000_0400, 1, 0);
        total++; if (bus.id_valid !== 1'b1 || bus.id_ctrl !== 6'd0 ||
                     {bus.id_aluop, bus.id_asrc, bus.id_bsrc, bus.id_sra, bus.id_shdir, bus.id_sub, bus.id_jalr} !== 9'd0) begin
            bad++; $display("FAIL ones_nop got valid=%0b ctrl=%b aluop=%0d want 1/0/0", bus.id_valid, bus.id_ctrl, bus.id_aluop); end
`ifdef ILLEGAL_TRAP_EN
        total++; if (bus.id_illegal !== 1'b1) begin bad++; $display("FAIL ones_illegal got=%0b want=1", bus.id_illegal); end
`endif
        drive(1, 32'h002081B3, 32'h0000_0404, 1, 0);
`ifdef ILLEGAL_TRAP_EN
        total++; if (bus.id_illegal !== 1'b0) begin bad++; $display("FAIL add_legal got=%0b want=0", bus.id_illegal); end
`endif
        drive(1, 32'h002081B0, 32'h0000_0408, 1, 0);
        total++; if (bus.id_ctrl !== 6'd0 || bus.id_sub !== 1'b0) begin
            bad++; $display("FAIL lowbits_nop got ctrl=%b want 000000", bus.id_ctrl); end
`ifdef ILLEGAL_TRAP_EN
        total++; if (bus.id_illegal !== 1'b1) begin bad++; $display("FAIL lowbits_illegal got=%0b want=1", bus.id_illegal); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)
                for (int r = 0; r < 32; r++) regs[r] = $urandom();
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b want=%0b", n, obs_ready, exp_ready); end
            total++; if (bus.id_valid !== m.valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%0b want=%0b", n, bus.id_valid, m.valid); end
            if (m.valid) begin
                total++; if (bus.id_pc !== m.pc || bus.id_rd !== m.rd || bus.id_funct3 !== m.f3) begin
                    bad++; $display("FAIL rnd_pc_rd n=%0d got pc=%h rd=%0d f3=%0d want pc=%h rd=%0d f3=%0d",
                                    n, bus.id_pc, bus.id_rd, bus.id_funct3, m.pc, m.rd, m.f3); end
                total++; if (bus.id_rs1_data !== m.rs1 || bus.id_rs2_data !== m.rs2) begin
                    bad++; $display("FAIL rnd_rs n=%0d got=%h/%h want=%h/%h", n, bus.id_rs1_data, bus.id_rs2_data, m.rs1, m.rs2); end
                total++; if (bus.id_imm !== m.imm) begin
                    bad++; $display("FAIL rnd_imm n=%0d got=%h want=%h", n, bus.id_imm, m.imm); end
                total++; if ({bus.id_aluop, bus.id_asrc, bus.id_bsrc, bus.id_sra, bus.id_shdir, bus.id_sub, bus.id_jalr} !==
                             {m.aluop, m.asrc, m.bsrc, m.sra, m.shdir, m.sub, m.jalr}) begin
                    bad++; $display("FAIL rnd_alu n=%0d got=%b want=%b", n,
                                    {bus.id_aluop, bus.id_asrc, bus.id_bsrc, bus.id_sra, bus.id_shdir, bus.id_sub, bus.id_jalr},
                                    {m.aluop, m.asrc, m.bsrc, m.sra, m.shdir, m.sub, m.jalr}); end
                total++; if (bus.id_ctrl !== m.ctrl) begin
                    bad++; $display("FAIL rnd_ctrl n=%0d got=%b want=%b", n, bus.id_ctrl, m.ctrl); end
`ifdef ILLEGAL_TRAP_EN
                total++; if (bus.id_illegal !== m.illegal) begin
                    bad++; $display("FAIL rnd_illegal n=%0d got=%0b want=%0b", n, bus.id_illegal, m.illegal); end
`endif
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = $urandom();
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b0;
        m = ref_decode(32'd0, 32'd0);
        m.valid = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_flush_reset();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
